// File: rtl/tsp_pkg.sv
// Shared TSP datapath constants and types: vector/position widths and the
// position encoder state encoding.
package tsp_pkg;

  localparam int unsigned POS_W = 6;
  localparam int unsigned VEC_W = 64;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned BIT_W = 3;

  // Encoder control states; 2'b11 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_FIN     = 2'b10
  } enc_state_e;

  // Serial position payload as it travels on the bus: {idx, bit} = idx*8+bit.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [BIT_W-1:0] bit_sel;
  } pos_fields_t;

  typedef logic [POS_W-1:0] pos_t;

  // Flat bit index of a structured position.
  function automatic pos_t pos_index(input pos_fields_t p);
    return pos_t'({p.idx, p.bit_sel});
  endfunction

endpackage

// File: rtl/onehot_6to64.sv
// Combinational 6-to-64 one-hot decode of a position, gated by accept.
module onehot_6to64
  import tsp_pkg::*;
(
  input  logic [POS_W-1:0] position,
  input  logic             accept,
  output logic [VEC_W-1:0] onehot_c
);

  // Single set bit at the position index, all zero when not accepting.
  always_comb begin
    onehot_c = '0;
    if (accept) begin
      onehot_c[position] = 1'b1;
    end
  end

endmodule

// File: rtl/position_encoder.sv
// Serial-to-bitmap encoder: collects 6-bit positions into a 64-bit vector and
// counts distinct set bits. Optional sticky duplicate flag via the
// POSENC_DUP_CHECK_EN macro (port `dup` exists only when it is defined).
module position_encoder
  import tsp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             valid,
  input  logic [POS_W-1:0] position,
  input  logic             last,
  output logic             idle,
  output logic             ready,
  output logic             done,
  output logic [VEC_W-1:0] bit_position,
  output logic [CNT_W-1:0] count
`ifdef POSENC_DUP_CHECK_EN
  ,
  output logic             dup
`endif
);

  enc_state_e       state_q;
  enc_state_e       state_n;
  logic [VEC_W-1:0] vec_n;
  logic [CNT_W-1:0] cnt_n;
  logic             accept_c;
  logic             new_bit_c;
  logic [VEC_W-1:0] onehot_c;

  // Acceptance depends only on the registered state, never on ready's flop.
  assign accept_c  = valid && (state_q == S_COLLECT);
  // A position counts only if its bit was not already in the vector.
  assign new_bit_c = ~|(bit_position & onehot_c);

  onehot_6to64 u_onehot (
    .position (position),
    .accept   (accept_c),
    .onehot_c (onehot_c)
  );

`ifdef POSENC_DUP_CHECK_EN
  logic dup_n;
`endif

  // Next-state and next-datapath decode; everything holds by default.
  always_comb begin
    state_n = state_q;
    vec_n   = bit_position;
    cnt_n   = count;
`ifdef POSENC_DUP_CHECK_EN
    dup_n   = dup;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_COLLECT;
          vec_n   = '0;
          cnt_n   = '0;
`ifdef POSENC_DUP_CHECK_EN
          dup_n   = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        // A position arriving with last is folded in before finishing.
        if (accept_c) begin
          vec_n = bit_position | onehot_c;
          if (new_bit_c) begin
            cnt_n = count + CNT_W'(1);
          end
`ifdef POSENC_DUP_CHECK_EN
          else begin
            dup_n = 1'b1;
          end
`endif
        end
        if (last) begin
          state_n = S_FIN;
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags follow the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idle         <= 1'b1;
      ready        <= 1'b0;
      done         <= 1'b0;
      bit_position <= '0;
      count        <= '0;
    end else begin
      state_q      <= state_n;
      idle         <= (state_n == S_IDLE);
      ready        <= (state_n == S_COLLECT);
      done         <= (state_n == S_FIN);
      bit_position <= vec_n;
      count        <= cnt_n;
    end
  end

`ifdef POSENC_DUP_CHECK_EN
  // Sticky duplicate flag, cleared by reset or a new collection.
  always_ff @(posedge clk) begin
    if (reset) begin
      dup <= 1'b0;
    end else begin
      dup <= dup_n;
    end
  end
`endif

endmodule

// File: tb/tb_position_encoder.sv
// Self-checking bench for position_encoder: table vectors, hand-written
// corner sequences and randomized traffic against a set-based reference model.
module tb_position_encoder;
  import tsp_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             valid;
  logic [POS_W-1:0] position;
  logic             last;
  logic             idle;
  logic             ready;
  logic             done;
  logic [VEC_W-1:0] bit_position;
  logic [CNT_W-1:0] count;
`ifdef POSENC_DUP_CHECK_EN
  logic             dup;
`endif

  position_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .valid        (valid),
    .position     (position),
    .last         (last),
    .idle         (idle),
    .ready        (ready),
    .done         (done),
    .bit_position (bit_position),
    .count        (count)
`ifdef POSENC_DUP_CHECK_EN
    ,
    .dup          (dup)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus for one transaction: a value >= 0 is a valid position, -1 is a
  // cycle with valid low (position randomised to prove it is ignored).
  int stim_q[$];
  bit stim_lwf;

  typedef struct {
    string       name;
    int          n;
    int          pos[6];
    bit          lwf;
    logic [63:0] vec;
    int          cnt;
    bit          dup;
  } vec_rec_t;

  vec_rec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set semantics: vector is the union of accepted positions.
  task automatic model(output logic [63:0] v, output int c, output bit d);
    int n;
    n = 0;
    v = '0;
    foreach (stim_q[i]) begin
      if (stim_q[i] >= 0) begin
        n++;
        v[6'(stim_q[i])] = 1'b1;
      end
    end
    c = $countones(v);
    d = (n > c);
  endtask

  // One full transaction with cycle-exact handshake checks.
  task automatic run_txn(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "/ready_after_start"}, 64'(ready), 64'd1);
    chk({name, "/idle_after_start"}, 64'(idle), 64'd0);
    foreach (stim_q[i]) begin
      if (stim_q[i] < 0) begin
        valid    = 1'b0;
        position = 6'($urandom);
      end else begin
        valid    = 1'b1;
        position = 6'(stim_q[i]);
      end
      last = stim_lwf && (i == stim_q.size() - 1);
      tick();
    end
    if (!(stim_lwf && stim_q.size() > 0)) begin
      valid = 1'b0;
      last  = 1'b1;
      tick();
    end
    valid = 1'b0;
    last  = 1'b0;
    chk({name, "/done_pulse"}, 64'(done), 64'd1);
    chk({name, "/ready_in_fin"}, 64'(ready), 64'd0);
    chk({name, "/idle_in_fin"}, 64'(idle), 64'd0);
    tick();
    chk({name, "/done_cleared"}, 64'(done), 64'd0);
    chk({name, "/idle_back"}, 64'(idle), 64'd1);
  endtask

  initial begin
    logic [63:0] v;
    logic [63:0] ev;
    int          ec;
    bit          ed;

    tbl[0] = '{"basic", 3, '{0, 9, 63, 0, 0, 0}, 1'b1, 64'h8000_0000_0000_0201, 3, 1'b0};
    tbl[1] = '{"dup5", 3, '{5, 5, 5, 0, 0, 0}, 1'b0, 64'h0000_0000_0000_0020, 1, 1'b1};
    tbl[2] = '{"low3", 3, '{1, 2, 3, 0, 0, 0}, 1'b0, 64'h0000_0000_0000_000e, 3, 1'b0};
    tbl[3] = '{"bare_last", 0, '{0, 0, 0, 0, 0, 0}, 1'b0, 64'h0, 0, 1'b0};
    tbl[4] = '{"gap", 3, '{10, -1, 20, 0, 0, 0}, 1'b1, 64'h0000_0000_0010_0400, 2, 1'b0};
    tbl[5] = '{"ends_dup", 4, '{63, 0, 63, 0, 0, 0}, 1'b1, 64'h8000_0000_0000_0001, 2, 1'b1};

    reset    = 1'b1;
    start    = 1'b0;
    valid    = 1'b0;
    last     = 1'b0;
    position = '0;
    repeat (2) tick();
    chk("reset/idle", 64'(idle), 64'd1);
    chk("reset/ready", 64'(ready), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/vec", bit_position, 64'd0);
    chk("reset/count", 64'(count), 64'd0);
`ifdef POSENC_DUP_CHECK_EN
    chk("reset/dup", 64'(dup), 64'd0);
`endif
    reset = 1'b0;
    tick();

    // Table vectors.
    for (int r = 0; r < 6; r++) begin
      stim_q.delete();
      for (int j = 0; j < tbl[r].n; j++) stim_q.push_back(tbl[r].pos[j]);
      stim_lwf = tbl[r].lwf;
      run_txn(tbl[r].name);
      chk({tbl[r].name, "/vec"}, bit_position, tbl[r].vec);
      chk({tbl[r].name, "/count"}, 64'(count), 64'(tbl[r].cnt));
`ifdef POSENC_DUP_CHECK_EN
      chk({tbl[r].name, "/dup"}, 64'(dup), 64'(tbl[r].dup));
`endif
    end

    // valid in idle has no effect; last result stays readable.
    valid    = 1'b1;
    position = 6'd7;
    tick();
    tick();
    valid = 1'b0;
    chk("idle_valid/vec", bit_position, tbl[5].vec);
    chk("idle_valid/count", 64'(count), 64'(tbl[5].cnt));
    chk("idle_valid/idle", 64'(idle), 64'd1);

    // start inside collection must not clear accumulated bits.
    start = 1'b1;
    tick();
    start    = 1'b0;
    valid    = 1'b1;
    position = 6'd4;
    tick();
    start    = 1'b1;
    position = 6'd6;
    tick();
    start = 1'b0;
    valid = 1'b0;
    chk("restart/ready_held", 64'(ready), 64'd1);
    last = 1'b1;
    tick();
    last = 1'b0;
    chk("restart/done", 64'(done), 64'd1);
    tick();
    chk("restart/vec", bit_position, 64'h50);
    chk("restart/count", 64'(count), 64'd2);

    // Full set.
    stim_q.delete();
    for (int b = 0; b < 64; b++) stim_q.push_back(b);
    stim_lwf = 1'b0;
    run_txn("full");
    chk("full/vec", bit_position, 64'hffff_ffff_ffff_ffff);
    chk("full/count", 64'(count), 64'd64);

    // Reset in the middle of a collection discards everything.
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      position = 6'(b);
      tick();
    end
    reset    = 1'b1;
    position = 6'd40;
    tick();
    reset = 1'b0;
    valid = 1'b0;
    chk("abort/idle", 64'(idle), 64'd1);
    chk("abort/ready", 64'(ready), 64'd0);
    chk("abort/done", 64'(done), 64'd0);
    chk("abort/vec", bit_position, 64'd0);
    chk("abort/count", 64'(count), 64'd0);

    // Round trip through a behavioural scanning decoder.
    for (int it = 0; it < 20; it++) begin
      v = {$urandom, $urandom};
      case (it % 4)
        0: v = v & {$urandom, $urandom} & {$urandom, $urandom};
        1: v = v | {$urandom, $urandom};
        default: ;
      endcase
      stim_q.delete();
      for (int b = 0; b < 64; b++) begin
        if ($urandom_range(0, 3) == 0) stim_q.push_back(-1);
        if (v[b]) stim_q.push_back(b);
      end
      stim_lwf = 1'($urandom_range(0, 1));
      run_txn($sformatf("trip%0d", it));
      chk($sformatf("trip%0d/vec", it), bit_position, v);
      chk($sformatf("trip%0d/count", it), 64'(count), 64'($countones(v)));
    end

    // Random traffic with forced repeats.
    for (int it = 0; it < 10; it++) begin
      stim_q.delete();
      for (int j = 0; j < int'($urandom_range(1, 20)); j++) begin
        if ($urandom_range(0, 4) == 0) stim_q.push_back(-1);
        else stim_q.push_back(int'($urandom_range(0, 15)) * 4);
      end
      stim_lwf = 1'($urandom_range(0, 1));
      model(ev, ec, ed);
      run_txn($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d/vec", it), bit_position, ev);
      chk($sformatf("rnd%0d/count", it), 64'(count), 64'(ec));
`ifdef POSENC_DUP_CHECK_EN
      chk($sformatf("rnd%0d/dup", it), 64'(dup), 64'(ed));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
